// File: rtl/testhps_dualport_ram_ctrl_if.sv
`default_nettype none
// Avalon-MM slave signal bundle for one port of testhps_dualport_ram_ctrl.
// Revision: 1.0
interface testhps_dualport_ram_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/testhps_dualport_ram_ctrl.sv
`default_nettype none
// True-dual-port RAM with two Avalon-MM slaves, pipelined reads, hardware clear,
// out-of-range protection and same-address write collision counting. Revision: 1.0
module testhps_dualport_ram_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 15,
  parameter int DEPTH          = 19200,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  testhps_dualport_ram_ctrl_if.slave port_a,
  testhps_dualport_ram_ctrl_if.slave port_b,
  input  wire logic                  clear_req,
  output logic                       busy,
  output logic                       oor_err,
  output logic [15:0]                collision_cnt
);
  localparam int                  BYTES     = DATA_WIDTH / 8;
  localparam int                  IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_ADDR = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   clr_ptr, clr_ptr_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic stall;
  logic acc_a, acc_b, wr_a, wr_b, rd_a, rd_b, inr_a, inr_b;
  logic collide, mem_wr_a, mem_wr_b, start_clear;
  logic [IDX_W-1:0]      idx_a, idx_b;
  logic [DATA_WIDTH-1:0] rdat_a, rdat_b;
  logic                  s1_valid_a, s1_valid_b;
  logic [DATA_WIDTH-1:0] s1_data_a, s1_data_b;

  // Stall is forced during reset so a design without power-up clear still refuses access.
  assign busy               = (state == CLEAR);
  assign stall              = busy | ~reset_n;
  assign port_a.waitrequest = stall;
  assign port_b.waitrequest = stall;

  assign acc_a = port_a.chipselect & (port_a.read | port_a.write) & ~stall;
  assign acc_b = port_b.chipselect & (port_b.read | port_b.write) & ~stall;
  assign wr_a  = acc_a & port_a.write;
  assign wr_b  = acc_b & port_b.write;
  assign rd_a  = acc_a & ~port_a.write;
  assign rd_b  = acc_b & ~port_b.write;
  assign inr_a = ({1'b0, port_a.address} < DEPTH_W);
  assign inr_b = ({1'b0, port_b.address} < DEPTH_W);
  assign idx_a = port_a.address[IDX_W-1:0];
  assign idx_b = port_b.address[IDX_W-1:0];

  assign collide     = wr_a & wr_b & inr_a & inr_b & (port_a.address == port_b.address);
  assign mem_wr_a    = wr_a & inr_a;
  assign mem_wr_b    = wr_b & inr_b & ~collide;
  assign start_clear = (state == READY) & clear_req;

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      CLEAR: begin
        if (clr_ptr == LAST_ADDR) begin
          state_next   = READY;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr + 1'b1;
        end
      end
      READY: begin
        if (clear_req) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      default: state_next = READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  // Port A wins a same-address collision, so port B is masked via mem_wr_b.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_ptr] <= '0;
    end else begin
      for (int i = 0; i < BYTES; i++) begin
        if (mem_wr_a && port_a.byteenable[i]) mem[idx_a][8*i +: 8] <= port_a.writedata[8*i +: 8];
        if (mem_wr_b && port_b.byteenable[i]) mem[idx_b][8*i +: 8] <= port_b.writedata[8*i +: 8];
      end
    end
  end

  // Sampling at the accept edge gives read-old-data against a concurrent write.
  assign rdat_a = inr_a ? mem[idx_a] : '0;
  assign rdat_b = inr_b ? mem[idx_b] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_a <= 1'b0;
      s1_valid_b <= 1'b0;
      s1_data_a  <= '0;
      s1_data_b  <= '0;
    end else begin
      s1_valid_a <= rd_a;
      s1_valid_b <= rd_b;
      if (rd_a) s1_data_a <= rdat_a;
      if (rd_b) s1_data_b <= rdat_b;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v_a, v_b;
      logic [DATA_WIDTH-1:0] q_a, q_b;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v_a <= 1'b0;
          v_b <= 1'b0;
          q_a <= '0;
          q_b <= '0;
        end else begin
          v_a <= s1_valid_a;
          v_b <= s1_valid_b;
          if (s1_valid_a) q_a <= s1_data_a;
          if (s1_valid_b) q_b <= s1_data_b;
        end
      end
      assign port_a.readdata      = q_a;
      assign port_a.readdatavalid = v_a;
      assign port_b.readdata      = q_b;
      assign port_b.readdatavalid = v_b;
    end else begin : g_lat1
      assign port_a.readdata      = s1_data_a;
      assign port_a.readdatavalid = s1_valid_a;
      assign port_b.readdata      = s1_data_b;
      assign port_b.readdatavalid = s1_valid_b;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oor_err       <= 1'b0;
      collision_cnt <= '0;
    end else begin
      if (start_clear) oor_err <= 1'b0;
      if ((acc_a && !inr_a) || (acc_b && !inr_b)) oor_err <= 1'b1;
      if (collide && (collision_cnt != 16'hFFFF)) collision_cnt <= collision_cnt + 16'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_testhps_dualport_ram_ctrl.sv
`default_nettype none
// Randomised scoreboard bench for testhps_dualport_ram_ctrl (DEPTH=16, READ_LATENCY=2).
// Revision: 1.0
module tb_testhps_dualport_ram_ctrl;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  localparam req_t IDLE = '0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear_req;
  logic        busy;
  logic        oor_err;
  logic [15:0] collision_cnt;

  testhps_dualport_ram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) pa ();
  testhps_dualport_ram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) pb ();

  testhps_dualport_ram_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .port_a(pa.slave), .port_b(pb.slave),
    .clear_req(clear_req), .busy(busy), .oor_err(oor_err), .collision_cnt(collision_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model [DEPTH];
  exp_t        exp_a[$];
  exp_t        exp_b[$];
  int          exp_coll = 0;
  logic        exp_oor  = 1'b0;
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic req_t mk(input logic rd, input logic wr, input logic [4:0] addr,
                              input logic [3:0] be, input logic [31:0] wd);
    req_t r;
    r.cs = 1'b1; r.rd = rd; r.wr = wr; r.addr = addr; r.be = be; r.wd = wd;
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] addr);
    return (int'(addr) < DEPTH) ? model[addr[3:0]] : 32'h0;
  endfunction

  task automatic model_wr(input req_t r);
    for (int i = 0; i < 4; i++)
      if (r.be[i]) model[r.addr[3:0]][8*i +: 8] = r.wd[8*i +: 8];
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // One bus cycle; expectations come from the array contents before this cycle's writes.
  task automatic do_cycle(input req_t a, input req_t b, input logic clr);
    @(negedge clk);
    pa.chipselect = a.cs; pa.read = a.rd; pa.write = a.wr;
    pa.address = a.addr; pa.byteenable = a.be; pa.writedata = a.wd;
    pb.chipselect = b.cs; pb.read = b.rd; pb.write = b.wr;
    pb.address = b.addr; pb.byteenable = b.be; pb.writedata = b.wd;
    clear_req = clr;
    if (a.cs && a.rd && !a.wr) exp_a.push_back('{model_rd(a.addr), cyc + LAT});
    if (b.cs && b.rd && !b.wr) exp_b.push_back('{model_rd(b.addr), cyc + LAT});
    if (a.cs && (a.rd || a.wr) && int'(a.addr) >= DEPTH) exp_oor = 1'b1;
    if (b.cs && (b.rd || b.wr) && int'(b.addr) >= DEPTH) exp_oor = 1'b1;
    if (a.cs && a.wr && int'(a.addr) < DEPTH) model_wr(a);
    if (b.cs && b.wr && int'(b.addr) < DEPTH) begin
      if (a.cs && a.wr && a.addr == b.addr) exp_coll++;
      else model_wr(b);
    end
    if (clr) begin
      model_zero();
      exp_oor = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    do_cycle(IDLE, IDLE, 1'b0);
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 10) begin
      do_cycle(IDLE, IDLE, 1'b0);
      n++;
    end
    check("drain_a", 32'(exp_a.size()), 32'd0);
    check("drain_b", 32'(exp_b.size()), 32'd0);
  endtask

  // Counts clock edges from the current negedge until busy drops.
  task automatic wait_clear(input string name);
    int n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!busy) break;
    end
    check(name, 32'(n), 32'(DEPTH));
    check({name, "_wreq_a"}, 32'(pa.waitrequest), 32'd0);
    check({name, "_wreq_b"}, 32'(pb.waitrequest), 32'd0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++)
      do_cycle(mk(1'b1, 1'b0, 5'(i), 4'h0, 32'h0), mk(1'b1, 1'b0, 5'(DEPTH - 1 - i), 4'h0, 32'h0), 1'b0);
    drain();
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic ev;
    if (!reset_n) begin
      last_a = '0;
    end else begin
      ev = (exp_a.size() != 0) && (exp_a[0].due == cyc);
      check("a_rdv", 32'(pa.readdatavalid), 32'(ev));
      if (ev) begin
        e = exp_a.pop_front();
        check("a_rdata", pa.readdata, e.data);
        last_a = e.data;
      end else begin
        check("a_hold", pa.readdata, last_a);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic ev;
    if (!reset_n) begin
      last_b = '0;
    end else begin
      ev = (exp_b.size() != 0) && (exp_b[0].due == cyc);
      check("b_rdv", 32'(pb.readdatavalid), 32'(ev));
      if (ev) begin
        e = exp_b.pop_front();
        check("b_rdata", pb.readdata, e.data);
        last_b = e.data;
      end else begin
        check("b_hold", pb.readdata, last_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t ra, rb;
    reset_n   = 1'b0;
    clear_req = 1'b0;
    {pa.chipselect, pa.read, pa.write, pa.address, pa.byteenable, pa.writedata} = '0;
    {pb.chipselect, pb.read, pb.write, pb.address, pb.byteenable, pb.writedata} = '0;
    model_zero();
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(busy), 32'd1);
    check("rst_wreq_a", 32'(pa.waitrequest), 32'd1);
    check("rst_wreq_b", 32'(pb.waitrequest), 32'd1);
    check("rst_rdv_a", 32'(pa.readdatavalid), 32'd0);
    check("rst_rdv_b", 32'(pb.readdatavalid), 32'd0);
    check("rst_rd_a", pa.readdata, 32'h0);
    check("rst_rd_b", pb.readdata, 32'h0);
    check("rst_oor", 32'(oor_err), 32'd0);
    check("rst_coll", 32'(collision_cnt), 32'd0);

    reset_n = 1'b1;
    wait_clear("init_clear_len");
    read_all();

    // Byte-lane write then cross-port read
    do_cycle(mk(1'b0, 1'b1, 5'd5, 4'b0011, 32'hDEADBEEF), IDLE, 1'b0);
    do_cycle(IDLE, mk(1'b1, 1'b0, 5'd5, 4'h0, 32'h0), 1'b0);
    drain();

    // Same-address dual write
    do_cycle(mk(1'b0, 1'b1, 5'd9, 4'hF, 32'h11111111), mk(1'b0, 1'b1, 5'd9, 4'hF, 32'h22222222), 1'b0);
    do_cycle(mk(1'b1, 1'b0, 5'd9, 4'h0, 32'h0), mk(1'b1, 1'b0, 5'd9, 4'h0, 32'h0), 1'b0);
    drain();
    check("coll_one", 32'(collision_cnt), 32'(exp_coll));

    // Read-during-write on opposite ports, then same-port write-then-read
    do_cycle(mk(1'b0, 1'b1, 5'd3, 4'hF, 32'hA), IDLE, 1'b0);
    do_cycle(mk(1'b1, 1'b0, 5'd3, 4'h0, 32'h0), mk(1'b0, 1'b1, 5'd3, 4'hF, 32'hB), 1'b0);
    do_cycle(mk(1'b1, 1'b0, 5'd3, 4'h0, 32'h0), mk(1'b0, 1'b1, 5'd7, 4'hF, 32'h77), 1'b0);
    do_cycle(IDLE, mk(1'b1, 1'b0, 5'd7, 4'h0, 32'h0), 1'b0);
    do_cycle(mk(1'b1, 1'b1, 5'd1, 4'hF, 32'h01010101), IDLE, 1'b0);
    drain();
    check("oor_before", 32'(oor_err), 32'd0);

    // Out-of-range read and write; address 17 aliases word 1 if the guard is missing
    do_cycle(mk(1'b1, 1'b0, 5'(DEPTH + 1), 4'h0, 32'h0), IDLE, 1'b0);
    do_cycle(mk(1'b0, 1'b1, 5'(DEPTH + 1), 4'hF, 32'h55), IDLE, 1'b0);
    do_cycle(mk(1'b1, 1'b0, 5'd1, 4'h0, 32'h0), IDLE, 1'b0);
    drain();
    check("oor_set", 32'(oor_err), 32'(exp_oor));

    for (int n = 0; n < 300; n++) begin
      ra = mk(1'($urandom), 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, DEPTH + 1)),
              4'($urandom), $urandom);
      rb = mk(1'($urandom), 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, DEPTH + 1)),
              4'($urandom), $urandom);
      ra.cs = ($urandom_range(0, 3) != 0);
      rb.cs = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) rb.addr = ra.addr;
      do_cycle(ra, rb, 1'b0);
    end
    drain();
    check("rand_coll", 32'(collision_cnt), 32'(exp_coll));
    check("rand_oor", 32'(oor_err), 32'(exp_oor));
    read_all();

    // Streaming reads, clear, then reset in the middle of the clear walk
    for (int i = 0; i < 8; i++)
      do_cycle(mk(1'b1, 1'b0, 5'(i), 4'h0, 32'h0), mk(1'b1, 1'b0, 5'(15 - i), 4'h0, 32'h0), 1'b0);
    do_cycle(IDLE, IDLE, 1'b1);
    @(negedge clk);
    clear_req = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_wreq_a", 32'(pa.waitrequest), 32'd1);
    check("clr_oor", 32'(oor_err), 32'(exp_oor));
    repeat (7) @(negedge clk);
    check("stream_left_a", 32'(exp_a.size()), 32'd0);
    check("stream_left_b", 32'(exp_b.size()), 32'd0);
    reset_n = 1'b0;
    exp_coll = 0;
    exp_oor  = 1'b0;
    model_zero();
    @(negedge clk);
    check("rst2_busy", 32'(busy), 32'd1);
    check("rst2_coll", 32'(collision_cnt), 32'd0);
    reset_n = 1'b1;
    wait_clear("restart_clear_len");
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
